// File: rtl/cam_dvp_capture_pkg.sv
// Shared camera definitions: capture FSM encoding, frame geometry and RGB565 layout.
// Also imported by the frame-buffer reader.
package cam_dvp_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_SKIP = 2'd2,
    ST_CAPT = 2'd3
  } cam_state_t;

  localparam int unsigned CAM_IMG_W    = 320;
  localparam int unsigned CAM_IMG_H    = 240;
  localparam int unsigned FRAME_PIXELS = CAM_IMG_W * CAM_IMG_H;

  // RGB565 field positions: r = [15:11], g = [10:5], b = [4:0]
  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  function automatic int unsigned frame_pixels(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction

endpackage

// File: rtl/cam_dvp_capture_if.sv
// DVP sensor bus plus frame-buffer write port of the capture stage.
// slave = capture block view, master = sensor/RAM environment view.
interface cam_dvp_capture_if #(
  parameter int unsigned ADDR_WIDTH = 18
);
  logic                  cam_vsync;
  logic                  cam_href;
  logic [7:0]            cam_data;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [15:0]           ram_din;
  logic                  ram_we;

  modport master (
    output cam_vsync, cam_href, cam_data,
    input  ram_addr, ram_din, ram_we
  );

  modport slave (
    input  cam_vsync, cam_href, cam_data,
    output ram_addr, ram_din, ram_we
  );
endinterface

// File: rtl/cam_dvp_capture_byte_pair.sv
// DVP input registers, vsync edge detection and byte-to-RGB565 pairing.
// All outputs are registered single-cycle pulses one edge after the input registers.
module cam_byte_pair (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic        pix_valid,
  output logic [15:0] pix_data,
  output logic        odd_err,
  output logic        vs_rise,
  output logic        vs_fall
);

  logic       vsync_q;
  logic       vsync_d;
  logic       href_q;
  logic [7:0] data_q;
  logic [7:0] hi_q;
  logic       toggle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q   <= 1'b0;
      vsync_d   <= 1'b0;
      href_q    <= 1'b0;
      data_q    <= '0;
      hi_q      <= '0;
      toggle    <= 1'b0;
      pix_valid <= 1'b0;
      pix_data  <= '0;
      odd_err   <= 1'b0;
      vs_rise   <= 1'b0;
      vs_fall   <= 1'b0;
    end else begin
      vsync_q   <= cam_vsync;
      vsync_d   <= vsync_q;
      href_q    <= cam_href;
      data_q    <= cam_data;
      vs_rise   <= vsync_q & ~vsync_d;
      vs_fall   <= ~vsync_q & vsync_d;
      pix_valid <= 1'b0;
      odd_err   <= 1'b0;
      if (href_q) begin
        if (!toggle) begin
          hi_q   <= data_q;
          toggle <= 1'b1;
        end else begin
          pix_data  <= {hi_q, data_q};
          pix_valid <= 1'b1;
          toggle    <= 1'b0;
        end
      end else begin
        // line ended on a high byte: drop the half pixel and flag it
        odd_err <= toggle;
        toggle  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cam_dvp_capture.sv
// Camera capture stage: frame gating with settle-frame skipping, frame-buffer
// write address/data/strobe generation and per-frame completion status.
module cam_dvp_capture
  import cam_dvp_capture_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 18,
  parameter int unsigned IMG_W       = CAM_IMG_W,
  parameter int unsigned IMG_H       = CAM_IMG_H,
  parameter int unsigned SKIP_FRAMES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap_en,
  cam_dvp_capture_if.slave  bus,
  output logic              frame_done,
  output logic              frame_ok,
  output logic [7:0]        frame_cnt
);

  localparam int unsigned FRAME_PIX = frame_pixels(IMG_W, IMG_H);
  localparam logic [ADDR_WIDTH:0]   CNT_FULL  = (ADDR_WIDTH+1)'(FRAME_PIX);
  localparam logic [ADDR_WIDTH:0]   CNT_OVER  = CNT_FULL + 1'b1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(FRAME_PIX - 1);
  localparam logic [7:0]            SKIP_LD   = 8'(SKIP_FRAMES);

  logic        pix_valid;
  logic [15:0] pix_data;
  logic        odd_err;
  logic        vs_rise;
  logic        vs_fall;

  cam_byte_pair u_pair (
    .clk       (clk),
    .rst_n     (rst_n),
    .cam_vsync (bus.cam_vsync),
    .cam_href  (bus.cam_href),
    .cam_data  (bus.cam_data),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .odd_err   (odd_err),
    .vs_rise   (vs_rise),
    .vs_fall   (vs_fall)
  );

  cam_state_t            state;
  cam_state_t            state_nxt;
  logic [7:0]            skip_cnt;
  logic [ADDR_WIDTH:0]   pix_cnt;
  logic [ADDR_WIDTH:0]   pix_cnt_nxt;
  logic                  odd_flag;
  logic                  odd_nxt;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [15:0]           ram_din_q;
  logic                  ram_we_q;

  logic load_skip;
  logic dec_skip;
  logic start_cap;
  logic end_frame;
  logic capturing;
  logic pix_in;
  logic pix_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_skip = 1'b0;
    dec_skip  = 1'b0;
    start_cap = 1'b0;
    end_frame = 1'b0;
    if (!cap_en) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_SYNC;
          load_skip = 1'b1;
        end
        ST_SYNC: begin
          if (vs_fall) begin
            if (skip_cnt != '0) begin
              dec_skip  = 1'b1;
              state_nxt = ST_SKIP;
            end else begin
              start_cap = 1'b1;
              state_nxt = ST_CAPT;
            end
          end
        end
        ST_SKIP: begin
          if (vs_rise) state_nxt = ST_SYNC;
        end
        ST_CAPT: begin
          if (vs_rise) begin
            end_frame = 1'b1;
            state_nxt = ST_SYNC;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end

    // Next-cycle counter/flag values feed the frame_ok decision so a pixel or
    // odd-byte event coinciding with the vsync edge is included.
    capturing   = cap_en && (state == ST_CAPT);
    pix_in      = capturing && pix_valid;
    pix_write   = pix_in && (pix_cnt < CNT_FULL);
    pix_cnt_nxt = (pix_in && (pix_cnt != CNT_OVER)) ? pix_cnt + 1'b1 : pix_cnt;
    odd_nxt     = odd_flag | (capturing && odd_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip_cnt   <= '0;
      pix_cnt    <= '0;
      odd_flag   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ram_we_q   <= 1'b0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      if (load_skip)     skip_cnt <= SKIP_LD;
      else if (dec_skip) skip_cnt <= skip_cnt - 1'b1;

      if (start_cap) begin
        pix_cnt  <= '0;
        odd_flag <= 1'b0;
      end else begin
        pix_cnt  <= pix_cnt_nxt;
        odd_flag <= odd_nxt;
      end

      ram_we_q <= pix_write;
      if (pix_write) ram_din_q <= pix_data;

      // address advances the cycle after a write and parks on the last word
      if (start_cap)
        ram_addr_q <= '0;
      else if (ram_we_q && (ram_addr_q != ADDR_LAST))
        ram_addr_q <= ram_addr_q + 1'b1;

      frame_done <= end_frame;
      if (end_frame) begin
        frame_ok  <= (pix_cnt_nxt == CNT_FULL) && !odd_nxt;
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_din  = ram_din_q;
  assign bus.ram_we   = ram_we_q;

endmodule
